// File: rtl/rf_pkg.sv
// Shared constants for the register-file sweep controller: FSM state encoding
// and sweep mode values.
package rf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_DUMP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic MODE_DUMP = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/rf_addr_cnt.sv
// AW-bit sweep pointer with synchronous clear and increment; wraps naturally
// to 0 after the all-ones entry, which is flagged on 'last'.
module rf_addr_cnt #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] ptr,
   output logic          last
);

   logic [AW-1:0] ptr_q;
   logic [AW-1:0] ptr_d;

   always_comb begin
      // NOTE: the hold assignment comes first so every path assigns ptr_d; no latch.
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr  = ptr_q;
   assign last = &ptr_q;

endmodule

// File: rtl/rf_sweep_ctrl.sv
// Register-file sweep controller: FILL writes one value to every entry, DUMP
// streams every entry out on a valid/ready port. Define RF_SWEEP_CHECKSUM_EN to add a checksum output.
module rf_sweep_ctrl
   import rf_pkg::*;
#(
   parameter int AW = 5,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [DW-1:0] fill_val,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rf_ra,
   input  logic [DW-1:0] rf_rd,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_wd,
   output logic          rf_we,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_addr,
   output logic          out_valid,
   input  logic          out_ready
`ifdef RF_SWEEP_CHECKSUM_EN
   ,
   output logic [DW-1:0] checksum
`endif
);

   state_e        state_q;
   state_e        state_d;
   logic [DW-1:0] fill_q;
   logic [DW-1:0] fill_d;
   logic [DW-1:0] out_data_q;
   logic [DW-1:0] out_data_d;
   logic [AW-1:0] out_addr_q;
   logic [AW-1:0] out_addr_d;
   logic          out_valid_q;
   logic          out_valid_d;

   logic [AW-1:0] ptr;
   logic          ptr_last;
   logic          accept;
   logic          load;
   logic          xfer;
   logic          cnt_inc;

   rf_addr_cnt #(.AW(AW)) u_ptr (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .inc  (cnt_inc),
      .ptr  (ptr),
      .last (ptr_last)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = (mode == MODE_FILL) ? ST_FILL : ST_DUMP;
         ST_FILL:  if (ptr_last) state_d = ST_DONE;
         ST_DUMP:  if (load && ptr_last) state_d = ST_DRAIN;
         ST_DRAIN: if (xfer) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_DONE);
      rf_we   = (state_q == ST_FILL);
      accept  = (state_q == ST_IDLE) && start;
      xfer    = out_valid_q && out_ready;
      // The output register reloads whenever it is empty or being drained this cycle.
      load    = (state_q == ST_DUMP) && (!out_valid_q || out_ready);
      cnt_inc = rf_we || load;
   end

   always_comb begin
      fill_d      = fill_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         fill_d = fill_val;
      end
      if (load) begin
         out_data_d  = rf_rd;
         out_addr_d  = ptr;
         out_valid_d = 1'b1;
      end else if (state_q == ST_DRAIN && xfer) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q      <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fill_q      <= fill_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef RF_SWEEP_CHECKSUM_EN
   logic [DW-1:0] checksum_q;
   logic [DW-1:0] checksum_d;

   // Running sum of accepted words, wrapping modulo 2^DW.
   always_comb begin
      checksum_d = checksum_q;
      if (accept) begin
         checksum_d = '0;
      end else if (xfer) begin
         checksum_d = checksum_q + out_data_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

   assign rf_ra     = ptr;
   assign rf_wa     = ptr;
   assign rf_wd     = fill_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rf_sweep_ctrl.sv
// Self-checking bench for rf_sweep_ctrl with a 4-entry behavioural register file;
// expected writes and dumped words are queued at stimulus time and popped by a monitor.
module tb_rf_sweep_ctrl;
   import rf_pkg::*;

   localparam int AW = 2;
   localparam int DW = 16;
   localparam int N  = 1 << AW;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic          mode;
   logic [DW-1:0] fill_val;
   logic          busy;
   logic          done;
   logic [AW-1:0] rf_ra;
   logic [DW-1:0] rf_rd;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic          rf_we;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_valid;
   logic          out_ready;
`ifdef RF_SWEEP_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int xfer_cnt = 0;
   int we_cnt = 0;

   exp_t wq[$];
   exp_t dq[$];
   exp_t mon_e;
   logic          stall_prev;
   logic [DW-1:0] held_data;
   logic [AW-1:0] held_addr;

   logic [DW-1:0] rf_mem [N];
   logic          tb_we;
   logic [AW-1:0] tb_wa;
   logic [DW-1:0] tb_wd;

   rf_sweep_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .fill_val  (fill_val),
      .busy      (busy),
      .done      (done),
      .rf_ra     (rf_ra),
      .rf_rd     (rf_rd),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .rf_we     (rf_we),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef RF_SWEEP_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural register file: DUT write port has priority over the bench preload port.
   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_wa] <= rf_wd;
      else if (tb_we) rf_mem[tb_wa] <= tb_wd;
   end
   assign rf_rd = rf_mem[rf_ra];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: scoreboard for writes and transfers, plus handshake stability.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         wq.delete();
         dq.delete();
      end else begin
         if (done) done_cnt++;
         if (rf_we) begin
            we_cnt++;
            check("wr_queued", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
               mon_e = wq.pop_front();
               check("wr_addr", 32'(rf_wa), 32'(mon_e.addr));
               check("wr_data", 32'(rf_wd), 32'(mon_e.data));
            end
         end
         if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(held_data));
            check("hold_addr", 32'(out_addr), 32'(held_addr));
         end
         if (out_valid && out_ready) begin
            xfer_cnt++;
            check("rd_queued", 32'(dq.size() != 0), 1);
            if (dq.size() != 0) begin
               mon_e = dq.pop_front();
               check("rd_addr", 32'(out_addr), 32'(mon_e.addr));
               check("rd_data", 32'(out_data), 32'(mon_e.data));
            end
         end
         stall_prev = out_valid && !out_ready;
         held_data  = out_data;
         held_addr  = out_addr;
      end
   end

   task automatic preload(input logic [DW-1:0] v0, v1, v2, v3);
      logic [DW-1:0] vals [N];
      vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
      for (int i = 0; i < N; i++) begin
         @(posedge clk); #1;
         tb_we = 1'b1; tb_wa = AW'(i); tb_wd = vals[i];
      end
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   task automatic push_fill(input logic [DW-1:0] v, input int count);
      for (int i = 0; i < count; i++) wq.push_back('{addr: AW'(i), data: v});
   endtask

   task automatic push_dump(input logic [DW-1:0] v0, v1, v2, v3);
      dq.push_back('{addr: 2'd0, data: v0});
      dq.push_back('{addr: 2'd1, data: v1});
      dq.push_back('{addr: 2'd2, data: v2});
      dq.push_back('{addr: 2'd3, data: v3});
   endtask

   // Leaves the bench 1 time unit after the edge that accepted start; t0 is that edge's cycle.
   task automatic start_sweep(input logic m, input logic [DW-1:0] v, output int t0);
      @(posedge clk); #1;
      start = 1'b1; mode = m; fill_val = v;
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int t0, input int budget, output int lat);
      lat = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - t0;
            break;
         end
      end
      check("done_seen", 32'(lat >= 0), 1);
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      check({tag, "_done_low"}, 32'(done), 0);
      check({tag, "_busy_low"}, 32'(busy), 0);
   endtask

   initial begin
      int t0, lat, d0, x0, w0;

      rst = 1'b1; start = 1'b0; mode = MODE_DUMP; fill_val = '0;
      out_ready = 1'b1; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_we", 32'(rf_we), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_addr", 32'(out_addr), 0);
      check("rst_ra", 32'(rf_ra), 0);
      check("rst_wa", 32'(rf_wa), 0);
      check("rst_wd", 32'(rf_wd), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1. FILL with A5A5
      push_fill(16'hA5A5, N);
      d0 = done_cnt; w0 = we_cnt;
      start_sweep(MODE_FILL, 16'hA5A5, t0);
      wait_done(t0, 20, lat);
      check("fill_latency", 32'(lat), 4);
      check("fill_we_cycles", 32'(we_cnt - w0), 4);
      check("fill_wq_empty", 32'(wq.size()), 0);
      after_done("fill");
      check("fill_done_pulses", 32'(done_cnt - d0), 1);
      for (int i = 0; i < N; i++) check("fill_mem", 32'(rf_mem[i]), 32'hA5A5);

      // 2. DUMP with ready held high
      preload(16'd1, 16'd2, 16'd3, 16'd4);
      push_dump(16'd1, 16'd2, 16'd3, 16'd4);
      d0 = done_cnt; x0 = xfer_cnt;
      start_sweep(MODE_DUMP, 16'h0, t0);
      @(negedge clk);
      check("dump_valid_first_cycle", 32'(out_valid), 0);
      check("dump_busy", 32'(busy), 1);
      @(negedge clk);
      check("dump_valid_second_cycle", 32'(out_valid), 1);
      wait_done(t0, 20, lat);
      check("dump_latency", 32'(lat), 5);
      check("dump_words", 32'(xfer_cnt - x0), 4);
      check("dump_dq_empty", 32'(dq.size()), 0);
`ifdef RF_SWEEP_CHECKSUM_EN
      check("dump_checksum", 32'(checksum), 32'd10);
`endif
      after_done("dump");
      check("dump_done_pulses", 32'(done_cnt - d0), 1);

      // 3. DUMP with back-pressure on the second word
      push_dump(16'd1, 16'd2, 16'd3, 16'd4);
      d0 = done_cnt; x0 = xfer_cnt;
      start_sweep(MODE_DUMP, 16'h0, t0);
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_addr", 32'(out_addr), 1);
      check("stall_data", 32'(out_data), 2);
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_done(t0, 30, lat);
      check("stall_latency", 32'(lat), 8);
      check("stall_words", 32'(xfer_cnt - x0), 4);
      check("stall_dq_empty", 32'(dq.size()), 0);
      after_done("stall");
      check("stall_done_pulses", 32'(done_cnt - d0), 1);

      // 4. start pulsed mid-DUMP is ignored
      push_dump(16'd1, 16'd2, 16'd3, 16'd4);
      d0 = done_cnt; x0 = xfer_cnt; w0 = we_cnt;
      start_sweep(MODE_DUMP, 16'h0, t0);
      @(posedge clk); #1;
      start = 1'b1; mode = MODE_FILL; fill_val = 16'hDEAD;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(t0, 20, lat);
      check("ign_latency", 32'(lat), 5);
      check("ign_words", 32'(xfer_cnt - x0), 4);
      after_done("ign");
      @(negedge clk);
      check("ign_still_idle", 32'(busy), 0);
      check("ign_no_writes", 32'(we_cnt - w0), 0);
      check("ign_done_pulses", 32'(done_cnt - d0), 1);

      // 5. Reset mid-FILL with ptr = 2, then a clean FILL
      push_fill(16'h1234, 2);
      start_sweep(MODE_FILL, 16'h1234, t0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_we", 32'(rf_we), 0);
      check("rst_mid_valid", 32'(out_valid), 0);
      check("rst_mid_wq_empty", 32'(wq.size()), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_mem0", 32'(rf_mem[0]), 32'h1234);
      check("rst_mid_mem1", 32'(rf_mem[1]), 32'h1234);
      check("rst_mid_mem2", 32'(rf_mem[2]), 32'd3);
      push_fill(16'h0F0F, N);
      w0 = we_cnt;
      start_sweep(MODE_FILL, 16'h0F0F, t0);
      wait_done(t0, 20, lat);
      check("refill_latency", 32'(lat), 4);
      check("refill_we_cycles", 32'(we_cnt - w0), 4);
      check("refill_wq_empty", 32'(wq.size()), 0);
      after_done("refill");
      for (int i = 0; i < N; i++) check("refill_mem", 32'(rf_mem[i]), 32'h0F0F);

`ifdef RF_SWEEP_CHECKSUM_EN
      // 6. Checksum wraps modulo 2^DW
      preload(16'hFFFF, 16'd1, 16'd2, 16'd3);
      push_dump(16'hFFFF, 16'd1, 16'd2, 16'd3);
      start_sweep(MODE_DUMP, 16'h0, t0);
      @(negedge clk);
      check("csum_cleared", 32'(checksum), 0);
      wait_done(t0, 20, lat);
      check("csum_at_done", 32'(checksum), 32'h0005);
      after_done("csum");
      check("csum_stable", 32'(checksum), 32'h0005);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
